score_keeper: RTL and testbench

//   Multi-digit BCD score counter for the Frogger display path.

---
 rtl/score_keeper.sv | 123 ++++++++++++
 tb/tb_score_keeper.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper
//   BCD score counter with high-score tracking for the Frogger display path.
//   Each 0->1 transition of inc adds one point while a game is in progress.
//   The score stops at all nines and does not wrap. On game_over the high
//   score keeps the larger of itself and the current score.
//   Both values are shown as per-digit BCD nibbles. Leading zeros are blanked
//   to 4'hF, so each nibble can drive one seven-segment decoder directly.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high; overrides every other input
//   inc        level input; each rising transition scores one point
//   game_over  one-cycle pulse: the frog lost its last life
//   new_game   one-cycle pulse: restart play and clear the score
//   digits     current score, digit i at [4i+3:4i], 4'hF = blank
//   hi_digits  high score, same encoding as digits
//   playing    1 while a game is in progress, 0 after game over
//   saturated  1 while the score is all nines
module score_keeper #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  game_over,
  input  logic                  new_game,
  output logic [4*DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0]   hi_digits,
  output logic                  playing,
  output logic                  saturated
);

  typedef enum logic {PLAY, OVER} state_t;

  state_t              state_reg;
  logic [4*DIGITS-1:0] score_reg;
  logic [4*DIGITS-1:0] hi_reg;
  logic                inc_q_reg;

  logic [4*DIGITS-1:0] score_next;
  logic [DIGITS:0]     carry;
  logic [DIGITS:0]     score_lz;   // bit i: digit i and every digit above it are zero
  logic [DIGITS:0]     hi_lz;
  logic                inc_edge;

  assign inc_edge = inc & ~inc_q_reg;

  // The increment ripples up from digit 0. A digit advances only when every
  // digit below it is 9. Carry out of the top digit means the score is all
  // nines, so that bit also acts as the saturation flag.
  always_comb begin
    carry      = '0;
    score_next = score_reg;
    carry[0]   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1] = carry[i] & (score_reg[4*i +: 4] == 4'd9);
      if (carry[i]) begin
        if (score_reg[4*i +: 4] == 4'd9) begin
          score_next[4*i +: 4] = 4'd0;
        end else begin
          score_next[4*i +: 4] = score_reg[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  // Leading-zero flags are built from the most significant digit downward.
  always_comb begin
    score_lz         = '0;
    hi_lz            = '0;
    score_lz[DIGITS] = 1'b1;
    hi_lz[DIGITS]    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      score_lz[i] = score_lz[i+1] & (score_reg[4*i +: 4] == 4'd0);
      hi_lz[i]    = hi_lz[i+1]    & (hi_reg[4*i +: 4]    == 4'd0);
    end
  end

  // Digit 0 always shows, so a zero score displays as a single "0".
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign digits[3:0]    = score_reg[3:0];
        assign hi_digits[3:0] = hi_reg[3:0];
      end else begin : g_upper
        assign digits[4*gi +: 4]    = score_lz[gi] ? 4'hF : score_reg[4*gi +: 4];
        assign hi_digits[4*gi +: 4] = hi_lz[gi]    ? 4'hF : hi_reg[4*gi +: 4];
      end
    end
  endgenerate

  assign saturated = carry[DIGITS];
  assign playing   = (state_reg == PLAY);

  // Priority on each edge: reset > new_game > game_over > inc edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= PLAY;
      score_reg <= '0;
      hi_reg    <= '0;
      inc_q_reg <= 1'b0;
    end else begin
      inc_q_reg <= inc;
      if (new_game) begin
        // An abandoned game does not count toward the high score.
        state_reg <= PLAY;
        score_reg <= '0;
      end else if (state_reg == PLAY) begin
        if (game_over) begin
          state_reg <= OVER;
          // Packed BCD with the MSD in the top bits orders like an unsigned number.
          if (score_reg > hi_reg) begin
            hi_reg <= score_reg;
          end
        end else if (inc_edge && !carry[DIGITS]) begin
          score_reg <= score_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic        clk;
  logic        reset;
  logic        inc;
  logic        game_over;
  logic        new_game;
  logic [15:0] digits;
  logic [15:0] hi_digits;
  logic        playing;
  logic        saturated;

  int checks = 0;
  int errors = 0;

  score_keeper #(.DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .game_over (game_over),
    .new_game  (new_game),
    .digits    (digits),
    .hi_digits (hi_digits),
    .playing   (playing),
    .saturated (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inc;
    logic        go;
    logic        ng;
    logic [15:0] exp_digits;
    logic [15:0] exp_hi;
    logic        exp_playing;
    logic        exp_sat;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] ed, input logic [15:0] eh,
                           input logic ep, input logic es);
    check({name, ".digits"}, digits, ed);
    check({name, ".hi"}, hi_digits, eh);
    check({name, ".playing"}, {15'd0, playing}, {15'd0, ep});
    check({name, ".saturated"}, {15'd0, saturated}, {15'd0, es});
    $display("%s: digits=%h hi=%h playing=%b saturated=%b", name, digits, hi_digits, playing, saturated);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      inc = 1'b1;
      step();
      inc = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inc = 1'b0;
    game_over = 1'b0;
    new_game = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Each record is applied for one cycle; expectations hold just after that edge.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'hFFF1, 16'hFFF0, 1'b1, 1'b0}; // first edge
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'hFFF1, 16'hFFF0, 1'b1, 1'b0}; // held, no edge
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'hFFF1, 16'hFFF0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'hFFF2, 16'hFFF0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'hFFF2, 16'hFFF2, 1'b0, 1'b0}; // game over, hi=2
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'hFFF2, 16'hFFF2, 1'b0, 1'b0}; // edge ignored in OVER
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'hFFF2, 16'hFFF2, 1'b0, 1'b0}; // game_over ignored
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'hFFF0, 16'hFFF2, 1'b1, 1'b0}; // new game
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'hFFF1, 16'hFFF2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'hFFF1, 16'hFFF2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'hFFF1, 16'hFFF2, 1'b0, 1'b0}; // go beats inc, 1<2
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'hFFF0, 16'hFFF2, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'hFFF1, 16'hFFF2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'hFFF1, 16'hFFF2, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'hFFF2, 16'hFFF2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'hFFF2, 16'hFFF2, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'hFFF3, 16'hFFF2, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 16'hFFF3, 16'hFFF3, 1'b0, 1'b0}; // 3>2, hi=3
    tbl[18] = '{1'b0, 1'b1, 1'b1, 16'hFFF0, 16'hFFF3, 1'b1, 1'b0}; // ng beats go in OVER
    tbl[19] = '{1'b1, 1'b0, 1'b0, 16'hFFF1, 16'hFFF3, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 16'hFFF0, 16'hFFF3, 1'b1, 1'b0}; // ng in PLAY, hi kept
    tbl[21] = '{1'b0, 1'b1, 1'b1, 16'hFFF0, 16'hFFF3, 1'b1, 1'b0}; // ng beats go in PLAY
    tbl[22] = '{1'b0, 1'b0, 1'b0, 16'hFFF0, 16'hFFF3, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 16'hFFF0, 16'hFFF3, 1'b1, 1'b0}; // ng beats inc edge

    // Reset state
    do_reset();
    check_all("reset", 16'hFFF0, 16'hFFF0, 1'b1, 1'b0);

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      inc       = tbl[v].inc;
      game_over = tbl[v].go;
      new_game  = tbl[v].ng;
      step();
      check_all($sformatf("vec%0d", v), tbl[v].exp_digits, tbl[v].exp_hi,
                tbl[v].exp_playing, tbl[v].exp_sat);
    end
    inc = 1'b0;
    game_over = 1'b0;
    new_game = 1'b0;

    // Counting, held inc, carry and blanking
    do_reset();
    pulse(12);
    check_all("count12", 16'hFF12, 16'hFFF0, 1'b1, 1'b0);
    inc = 1'b1;
    repeat (10) step();
    inc = 1'b0;
    step();
    check_all("held_inc", 16'hFF13, 16'hFFF0, 1'b1, 1'b0);
    pulse(86);
    check_all("score99", 16'hFF99, 16'hFFF0, 1'b1, 1'b0);
    inc = 1'b1;
    step();
    check_all("carry100", 16'hF100, 16'hFFF0, 1'b1, 1'b0);
    inc = 1'b0;
    step();

    // Saturation at 9999
    pulse(9898);
    check_all("score9998", 16'h9998, 16'hFFF0, 1'b1, 1'b0);
    pulse(3);
    check_all("saturate", 16'h9999, 16'hFFF0, 1'b1, 1'b1);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_all("sat_over", 16'h9999, 16'h9999, 1'b0, 1'b1);

    // High score kept across a lower game
    do_reset();
    check_all("reset2", 16'hFFF0, 16'hFFF0, 1'b1, 1'b0);
    pulse(42);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_all("hi42", 16'hFF42, 16'hFF42, 1'b0, 1'b0);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    pulse(7);
    check_all("score7", 16'hFFF7, 16'hFF42, 1'b1, 1'b0);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check_all("hi_kept", 16'hFFF7, 16'hFF42, 1'b0, 1'b0);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check_all("newgame", 16'hFFF0, 16'hFF42, 1'b1, 1'b0);

    // Simultaneous-event corners and mid-count reset
    do_reset();
    pulse(5);
    inc = 1'b1;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    inc = 1'b0;
    check_all("go_and_inc", 16'hFFF5, 16'hFFF5, 1'b0, 1'b0);
    new_game = 1'b1;
    game_over = 1'b1;
    step();
    new_game = 1'b0;
    game_over = 1'b0;
    check_all("ng_and_go", 16'hFFF0, 16'hFFF5, 1'b1, 1'b0);
    pulse(3);
    check_all("score3", 16'hFFF3, 16'hFFF5, 1'b1, 1'b0);
    inc = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    inc = 1'b0;
    check_all("mid_reset", 16'hFFF0, 16'hFFF0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
